// File: rtl/csr_bus_arbiter_pkg.sv
// Shared constants for the CSR peripheral bus: field widths, modify codes and
// the arbiter's phase encoding.
package csr_bus_pkg;

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned CSR_DATA_W = 32;

    // Modify codes seen by peripherals; codes 1xx are passed through untouched.
    localparam logic [2:0] MOD_NONE  = 3'b000;
    localparam logic [2:0] MOD_WRITE = 3'b001;
    localparam logic [2:0] MOD_SET   = 3'b010;
    localparam logic [2:0] MOD_CLEAR = 3'b011;

    // Access phases: accept in IDLE, drive payload in ADDR, collect in DATA.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/csr_bus_arbiter_if.sv
// Requester-side handshake plus peripheral-side bus of the CSR arbiter.
// The master modport is the arbiter's view; slave is the environment's view
// (requesters and the OR-merged peripheral return path).
interface csr_bus_arbiter_if #(
    parameter int unsigned NREQ = 2
) ();
    import csr_bus_pkg::*;

    // Requester side
    logic [NREQ-1:0]            req;
    logic [NREQ*CSR_ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]            req_read;
    logic [NREQ*3-1:0]          req_modify;
    logic [NREQ*CSR_DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]            gnt;
    logic [NREQ-1:0]            rsp_valid;
    logic [CSR_DATA_W-1:0]      rsp_rdata;
    logic                       rsp_err;

    // Peripheral side
    logic [CSR_ADDR_W-1:0]      bus_addr;
    logic                       bus_read;
    logic [2:0]                 bus_modify;
    logic [CSR_DATA_W-1:0]      bus_wdata;
    logic [CSR_DATA_W-1:0]      bus_rdata;
    logic                       bus_valid;

    modport master (
        input  req, req_addr, req_read, req_modify, req_wdata,
        output gnt, rsp_valid, rsp_rdata, rsp_err,
        output bus_addr, bus_read, bus_modify, bus_wdata,
        input  bus_rdata, bus_valid
    );

    modport slave (
        output req, req_addr, req_read, req_modify, req_wdata,
        input  gnt, rsp_valid, rsp_rdata, rsp_err,
        input  bus_addr, bus_read, bus_modify, bus_wdata,
        output bus_rdata, bus_valid
    );

endinterface

// File: rtl/csr_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant to the first requester
// found searching upward from (last+1) mod NREQ, or zero if none requests.
module rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  gnt
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the ring once; the requester just served is visited last.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((32'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_bus_arbiter.sv
// Shares one CSR peripheral bus among NREQ requesters. Every access runs a
// fixed ADDR/DATA phase pair so each peripheral sees exactly one modify pulse;
// the merged read data and an "unmapped" error come back one cycle after DATA.
module csr_bus_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter logic [11:0] IDLE_ADDR = 12'h000
) (
    input logic               clk,
    input logic               rst,
    csr_bus_arbiter_if.master bus
);
    import csr_bus_pkg::*;

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      last_q;
    logic [NREQ-1:0]       pick;
    logic                  accept;

    // Winner payload, selected from the requester slices
    logic [IDX_W-1:0]      win_idx;
    logic [CSR_ADDR_W-1:0] win_addr;
    logic                  win_read;
    logic [2:0]            win_modify;
    logic [CSR_DATA_W-1:0] win_wdata;

    // Latched access
    logic [CSR_ADDR_W-1:0] addr_q;
    logic                  read_q;
    logic [2:0]            modify_q;
    logic [CSR_DATA_W-1:0] wdata_q;

    // Registered response
    logic [NREQ-1:0]       rsp_valid_q;
    logic [CSR_DATA_W-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (bus.req),
        .last (last_q),
        .gnt  (pick)
    );

    assign accept  = (state_q == ST_IDLE) && (|bus.req);
    assign bus.gnt = (state_q == ST_IDLE) ? pick : '0;

    // Mux the winning requester's index and payload out of the packed slices.
    always_comb begin
        win_idx    = '0;
        win_addr   = '0;
        win_read   = 1'b0;
        win_modify = MOD_NONE;
        win_wdata  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                win_idx    = IDX_W'(i);
                win_addr   = bus.req_addr[i*CSR_ADDR_W +: CSR_ADDR_W];
                win_read   = bus.req_read[i];
                win_modify = bus.req_modify[i*3 +: 3];
                win_wdata  = bus.req_wdata[i*CSR_DATA_W +: CSR_DATA_W];
            end
        end
    end

    // Phase sequencing: IDLE -> ADDR on accept, then DATA, then back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture winner payload and index on accept; last_q doubles as the
    // index of the access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= IDX_W'(NREQ - 1);
            addr_q   <= '0;
            read_q   <= 1'b0;
            modify_q <= MOD_NONE;
            wdata_q  <= '0;
        end else if (accept) begin
            last_q   <= win_idx;
            addr_q   <= win_addr;
            read_q   <= win_read;
            modify_q <= win_modify;
            wdata_q  <= win_wdata;
        end
    end

    // Bus drive per phase; DATA keeps the address but zeroes modify so the
    // peripherals' re-decode has no side effect.
    always_comb begin
        bus.bus_addr   = IDLE_ADDR;
        bus.bus_read   = 1'b0;
        bus.bus_modify = MOD_NONE;
        bus.bus_wdata  = '0;
        case (state_q)
            ST_ADDR: begin
                bus.bus_addr   = addr_q;
                bus.bus_read   = read_q;
                bus.bus_modify = modify_q;
                bus.bus_wdata  = wdata_q;
            end
            ST_DATA: begin
                bus.bus_addr = addr_q;
            end
            default: ;
        endcase
    end

    // Collect the peripheral answer at the end of DATA; data/err hold until
    // the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (state_q == ST_DATA) begin
                rsp_valid_q <= NREQ'(1) << last_q;
                rsp_rdata_q <= bus.bus_valid ? bus.bus_rdata : '0;
                rsp_err_q   <= ~bus.bus_valid;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Bench for csr_bus_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a timeline model of the access protocol.
module tb_csr_bus_arbiter;
    import csr_bus_pkg::*;

    localparam int          N    = 3;
    localparam logic [11:0] IDLE = 12'h000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_bus_arbiter_if #(.NREQ(N)) bif ();

    csr_bus_arbiter #(
        .NREQ      (N),
        .IDLE_ADDR (IDLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Requester stimulus
    logic        r_req   [N];
    logic [11:0] r_addr  [N];
    logic        r_read  [N];
    logic [2:0]  r_mod   [N];
    logic [31:0] r_wdata [N];
    logic        held    [N];

    always_comb begin
        bif.req        = '0;
        bif.req_addr   = '0;
        bif.req_read   = '0;
        bif.req_modify = '0;
        bif.req_wdata  = '0;
        for (int i = 0; i < N; i++) begin
            bif.req[i]                = r_req[i];
            bif.req_addr[12*i +: 12]  = r_addr[i];
            bif.req_read[i]           = r_read[i];
            bif.req_modify[3*i +: 3]  = r_mod[i];
            bif.req_wdata[32*i +: 32] = r_wdata[i];
        end
    end

    // Peripheral population: 12'hF10..F1F and 12'hBC0..BCF are mapped.
    function automatic bit is_mapped(input logic [11:0] a);
        return (a[11:4] == 8'hF1) || (a[11:4] == 8'hBC);
    endfunction

    function automatic int map_idx(input logic [11:0] a);
        return ((a[11:4] == 8'hBC) ? 16 : 0) + int'(a[3:0]);
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return (i == 1) ? 32'h0000_0005 : (32'hA500_0000 | 32'(i));
    endfunction

    logic [31:0] p_mem [64];
    int          pulse_cnt = 0;

    // Registered peripherals; unmapped cycles return garbage data with valid low.
    always @(posedge clk) begin
        if (bif.bus_modify != 3'b000) pulse_cnt <= pulse_cnt + 1;
        if (rst) begin
            for (int i = 0; i < 64; i++) p_mem[i] <= init_val(i);
            bif.bus_valid <= 1'b0;
            bif.bus_rdata <= '0;
        end else if (is_mapped(bif.bus_addr)) begin
            bif.bus_valid <= 1'b1;
            bif.bus_rdata <= p_mem[map_idx(bif.bus_addr)];
            case (bif.bus_modify)
                MOD_WRITE: p_mem[map_idx(bif.bus_addr)] <= bif.bus_wdata;
                MOD_SET:   p_mem[map_idx(bif.bus_addr)] <= p_mem[map_idx(bif.bus_addr)] | bif.bus_wdata;
                MOD_CLEAR: p_mem[map_idx(bif.bus_addr)] <= p_mem[map_idx(bif.bus_addr)] & ~bif.bus_wdata;
                default: ;
            endcase
        end else begin
            bif.bus_valid <= 1'b0;
            bif.bus_rdata <= $urandom;
        end
    end

    // Reference model: accept time plus payload; everything else follows from it.
    int          cyc = 0;
    int          acc_t = -100;
    int          m_last = N - 1;
    int          a_win = 0;
    logic [11:0] a_addr;
    logic        a_read;
    logic [2:0]  a_mod;
    logic [31:0] a_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_err;
    logic [31:0] ref_mem [64];
    int          exp_pulses = 0;
    int          g_who [$];
    int          g_when [$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit any_req();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r |= r_req[i];
        return r;
    endfunction

    task automatic model_reset();
        acc_t       = -100;
        m_last      = N - 1;
        m_rsp_rdata = '0;
        m_rsp_err   = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        g_who.delete();
        g_when.delete();
    endtask

    task automatic check_cycle(output int w);
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        logic [11:0]  ea;
        logic         er;
        logic [2:0]   em;
        logic [31:0]  ew;
        w  = -1;
        eg = '0;
        if (cyc >= acc_t + 3) begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && r_req[(m_last + k) % N]) w = (m_last + k) % N;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        ea = IDLE; er = 1'b0; em = 3'b000; ew = '0;
        if (cyc == acc_t + 1) begin
            ea = a_addr; er = a_read; em = a_mod; ew = a_wdata;
        end else if (cyc == acc_t + 2) begin
            ea = a_addr;
        end
        erv = '0;
        if (cyc == acc_t + 3) begin
            erv[a_win]  = 1'b1;
            m_rsp_rdata = e_rdata;
            m_rsp_err   = e_err;
        end
        chk("gnt",        32'(bif.gnt),        32'(eg));
        chk("bus_addr",   32'(bif.bus_addr),   32'(ea));
        chk("bus_read",   32'(bif.bus_read),   32'(er));
        chk("bus_modify", 32'(bif.bus_modify), 32'(em));
        chk("bus_wdata",  bif.bus_wdata,       ew);
        chk("rsp_valid",  32'(bif.rsp_valid),  32'(erv));
        chk("rsp_rdata",  bif.rsp_rdata,       m_rsp_rdata);
        chk("rsp_err",    32'(bif.rsp_err),    32'(m_rsp_err));
    endtask

    task automatic accept(input int w);
        acc_t   = cyc;
        a_win   = w;
        a_addr  = r_addr[w];
        a_read  = r_read[w];
        a_mod   = r_mod[w];
        a_wdata = r_wdata[w];
        m_last  = w;
        g_who.push_back(w);
        g_when.push_back(cyc);
        if (is_mapped(a_addr)) begin
            e_rdata = ref_mem[map_idx(a_addr)];
            e_err   = 1'b0;
            if (a_mod == 3'b001) ref_mem[map_idx(a_addr)] = a_wdata;
            if (a_mod == 3'b010) ref_mem[map_idx(a_addr)] = e_rdata | a_wdata;
            if (a_mod == 3'b011) ref_mem[map_idx(a_addr)] = e_rdata & ~a_wdata;
        end else begin
            e_rdata = '0;
            e_err   = 1'b1;
        end
        if (a_mod != 3'b000) exp_pulses++;
        if (!held[w]) r_req[w] = 1'b0;
    endtask

    task automatic step();
        int   w;
        logic r;
        #1;
        check_cycle(w);
        r = rst;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else if (w >= 0) accept(w);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0;
            held[i]  = 1'b0;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_req(input int i, input logic [11:0] a, input logic rd,
                           input logic [2:0] m, input logic [31:0] wd);
        r_addr[i]  = a;
        r_read[i]  = rd;
        r_mod[i]   = m;
        r_wdata[i] = wd;
        r_req[i]   = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((any_req() || cyc < acc_t + 4) && n < budget) begin
            step();
            n++;
        end
        chk("drain", 32'(any_req() || cyc < acc_t + 4), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0; r_addr[i] = '0; r_read[i] = 1'b0;
            r_mod[i] = '0;   r_wdata[i] = '0; held[i] = 1'b0;
        end

        // Reset state, then a mapped read by requester 0
        do_reset();
        step();
        set_req(0, 12'hF11, 1'b1, MOD_NONE, 32'h0);
        wait_idle(20);
        chk("read_f11_data", e_rdata, 32'h0000_0005);

        // Unmapped read by requester 1
        set_req(1, 12'h123, 1'b1, MOD_NONE, 32'h0);
        wait_idle(20);

        // Write: modify pulse only in ADDR
        set_req(0, 12'hBC1, 1'b0, MOD_WRITE, 32'h3);
        wait_idle(20);
        set_req(2, 12'hBC1, 1'b1, MOD_NONE, 32'h0);
        wait_idle(20);
        chk("write_readback", m_rsp_rdata, 32'h3);

        // Two requesters held from reset alternate 0,1,0,1 every 3 cycles
        do_reset();
        held[0] = 1'b1; held[1] = 1'b1;
        set_req(0, 12'hF10, 1'b1, MOD_NONE, 32'h0);
        set_req(1, 12'hF12, 1'b1, MOD_NONE, 32'h0);
        repeat (12) step();
        chk("alt_count", 32'(g_who.size()), 32'd4);
        for (int k = 0; k < g_who.size() && k < 4; k++) begin
            chk("alt_who", 32'(g_who[k]), 32'(k % 2));
            chk("alt_when", 32'(g_when[k] - g_when[0]), 32'(3 * k));
        end
        held[0] = 1'b0; held[1] = 1'b0;
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        wait_idle(20);

        // Reset during DATA aborts the access; requester 0 wins afterwards
        do_reset();
        set_req(0, 12'hF11, 1'b1, MOD_NONE, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 12'hF14, 1'b1, MOD_NONE, 32'h0);
        set_req(1, 12'hF15, 1'b1, MOD_NONE, 32'h0);
        step();
        chk("rst_grants", 32'(g_who.size()), 32'd1);
        if (g_who.size() > 0) chk("rst_first_win", 32'(g_who[0]), 32'd0);
        wait_idle(30);

        // Requester 1 held; requester 0 raised mid-access wins the next slot
        do_reset();
        held[1] = 1'b1;
        set_req(1, 12'hBC2, 1'b0, MOD_SET, 32'h0000_0100);
        step();
        step();
        set_req(0, 12'hF13, 1'b1, MOD_NONE, 32'h0);
        repeat (7) step();
        chk("mid_count", 32'(g_who.size()), 32'd3);
        if (g_who.size() >= 3) begin
            chk("mid_who1", 32'(g_who[1]), 32'd0);
            chk("mid_when1", 32'(g_when[1] - g_when[0]), 32'd3);
            chk("mid_who2", 32'(g_who[2]), 32'd1);
        end
        held[1] = 1'b0;
        r_req[1] = 1'b0;
        wait_idle(20);

        // Random traffic from all requesters
        for (int c = 0; c < 900; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 2))
                            0:       r_addr[i] = {8'hF1, 4'($urandom)};
                            1:       r_addr[i] = {8'hBC, 4'($urandom)};
                            default: r_addr[i] = 12'($urandom);
                        endcase
                        r_read[i]  = 1'($urandom_range(0, 1));
                        r_mod[i]   = 3'($urandom_range(0, 7));
                        r_wdata[i] = $urandom;
                        r_req[i]   = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    r_req[i] = 1'b0;
                end
            end
            step();
        end
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
        wait_idle(20);
        chk("mod_pulses", 32'(pulse_cnt), 32'(exp_pulses));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
